binary_counter_ctrl: RTL and testbench
======================================

Name: binary_counter_ctrl

Overview:
Sequencing controller for the team's 4-bit binary counter datapath (synchronous clear, count enable, free wrap at 1111).
- Drives the counter's enable and clear.
- Observes the counter value.
- Runs one-shot or periodic count cycles up to a programmable limit, with a programmable clock prescaler.
- Exposes a cfg valid/ready handshake, start/stop/pause control and done/period status to the surrounding design.

Parameters:
WIDTH, 4, width of counter value and limit
PSC_W, 4, width of prescaler compare value
PER_W, 8, width of completed-period counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
cfg_valid  input  1  configuration offered
cfg_ready  output  1  configuration accepted when high with cfg_valid
cfg_limit  input  WIDTH  terminal count value
cfg_prescale  input  PSC_W  tick every cfg_prescale+1 clk cycles
cfg_mode  input  1  0 = one-shot, 1 = periodic
start  input  1  start request (single-cycle or level)
stop  input  1  abort request
pause  input  1  level; freezes counting while high
cnt_val  input  WIDTH  current value from counter datapath
cnt_en  output  1  counter increment enable
cnt_clr  output  1  counter synchronous clear (priority over cnt_en in datapath)
busy  output  1  state is RUN or PAUSE
done  output  1  one-cycle pulse at terminal count
periods  output  PER_W  completed periods, saturating
state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE

Behaviour:
- Reset (async): state IDLE; limit = all ones; prescale = 0; mode = 0; psc = 0; periods = 0.
- Reset output values: cfg_ready 1, cnt_clr 1 (IDLE), cnt_en 0, done 0, busy 0.
- Reset mid-run aborts immediately; no done.
- Outputs cnt_en, cnt_clr, done are combinational from registered state, psc, registers and cnt_val only. No combinational path from start/stop/pause/cfg_* to outputs.
- cfg_ready = 1 in IDLE or DONE, else 0.
- On cfg_valid & cfg_ready, latch limit/prescale/mode at the edge.
- cfg offered in RUN/PAUSE is not accepted; it is held off, not dropped.
- IDLE:
  - cnt_clr = 1 continuously.
  - start → RUN; psc → 0; periods → 0.
  - A cfg accepted in the same cycle as start is used by that run.
- RUN:
  - tick = (psc == prescale). psc increments each cycle, returning to 0 on tick.
  - On tick with cnt_val != limit: cnt_en = 1.
  - On tick with cnt_val == limit: cnt_clr = 1, cnt_en = 0, done = 1, periods += 1 (saturate at 2^PER_W-1).
  - After terminal tick: mode 1 stays RUN; mode 0 → DONE.
  - Period = (limit+1)*(prescale+1) cycles.
  - limit = 0: every tick is terminal.
  - prescale = 0: tick every cycle.
- PAUSE:
  - Entered from RUN when pause sampled high; psc, counter and periods frozen.
  - cnt_en = cnt_clr = done = 0.
  - pause low → RUN, resuming at the frozen psc.
- DONE:
  - cnt_en = cnt_clr = 0; counter holds 0; periods held.
  - start → RUN (periods → 0, psc → 0).
- Next-state priority: stop > pause > start.
  - stop in RUN, PAUSE or DONE → IDLE next cycle.
  - A tick in the same cycle as stop is still executed, including done and the periods update.
  - start while RUN/PAUSE is ignored.
- If cnt_val exceeds limit (limit lowered is impossible mid-run, but a datapath fault is possible): controller keeps enabling. The datapath wraps 1111→0000 and terminal is detected on reaching limit.

Test Plan:
1. cfg limit=3, prescale=0, mode=0; start at cycle 0 → RUN cycles 1-4; cnt_en high cycles 1-3 (cnt_val 0,1,2); cycle 4 cnt_val=3: cnt_clr=1, done=1; state DONE cycle 5; periods=1.
2. limit=2, prescale=2, mode=1, run 30 cycles → done every 9 cycles exactly; cnt_en only on ticks; periods=3 after 27 RUN cycles.
3. Periodic run with limit=0, prescale=0, for 300 cycles → done every cycle; periods saturates at 255, never wraps.
4. pause high 5 cycles mid-period with cnt_val=1, psc=1 (prescale=3) → state PAUSE, no cnt_en/done; on release, next tick after 2 more cycles; period extended by exactly 5.
5. stop asserted on terminal tick cycle → done pulses once, state IDLE next cycle, cnt_clr high thereafter; start+cfg(limit=5) same cycle → new limit used, first done after 6 cycles.
6. rst asserted mid-RUN (cnt_val=7), between clock edges → outputs return to reset values immediately; cfg_valid during RUN → cfg_ready=0 and registers unchanged.

Source files
------------

// File: rtl/binary_counter_ctrl_if.sv
// Control/status bundle between the counter sequencer and its surroundings,
// including the observe/drive lines to the 4-bit counter datapath.
interface binary_counter_ctrl_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PSC_W = 4,
  parameter int unsigned PER_W = 8
) ();
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_limit;
  logic [PSC_W-1:0] cfg_prescale;
  logic             cfg_mode;
  logic             start;
  logic             stop;
  logic             pause;
  logic [WIDTH-1:0] cnt_val;
  logic             cnt_en;
  logic             cnt_clr;
  logic             busy;
  logic             done;
  logic [PER_W-1:0] periods;
  logic [1:0]       state;

  modport master (
    output cfg_valid, cfg_limit, cfg_prescale, cfg_mode, start, stop, pause, cnt_val,
    input  cfg_ready, cnt_en, cnt_clr, busy, done, periods, state
  );

  modport slave (
    input  cfg_valid, cfg_limit, cfg_prescale, cfg_mode, start, stop, pause, cnt_val,
    output cfg_ready, cnt_en, cnt_clr, busy, done, periods, state
  );
endinterface

// File: rtl/binary_counter_ctrl.sv
// Sequencer for the 4-bit binary counter: one-shot or periodic count cycles
// up to a programmable limit, paced by a programmable prescaler.
module binary_counter_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PSC_W = 4,
  parameter int unsigned PER_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  binary_counter_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [PSC_W-1:0] prescale_q, prescale_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             mode_q, mode_d;
  logic [PER_W-1:0] periods_q, periods_d;

  logic cfg_ready_c;
  logic tick_c;
  logic term_c;
  logic cnt_en_c;
  logic cnt_clr_c;
  logic done_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      limit_q    <= '1;
      prescale_q <= '0;
      psc_q      <= '0;
      mode_q     <= 1'b0;
      periods_q  <= '0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      prescale_q <= prescale_d;
      psc_q      <= psc_d;
      mode_q     <= mode_d;
      periods_q  <= periods_d;
    end
  end

  // Outputs depend only on registered state and cnt_val; control inputs only steer next state.
  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    prescale_d = prescale_q;
    psc_d      = psc_q;
    mode_d     = mode_q;
    periods_d  = periods_q;
    cnt_en_c   = 1'b0;
    cnt_clr_c  = 1'b0;
    done_c     = 1'b0;

    cfg_ready_c = (state_q == ST_IDLE) || (state_q == ST_DONE);
    tick_c      = (state_q == ST_RUN) && (psc_q == prescale_q);
    term_c      = tick_c && (bus.cnt_val == limit_q);

    if (cfg_ready_c && bus.cfg_valid) begin
      limit_d    = bus.cfg_limit;
      prescale_d = bus.cfg_prescale;
      mode_d     = bus.cfg_mode;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_clr_c = 1'b1;
        if (!bus.stop && bus.start) begin
          state_d   = ST_RUN;
          psc_d     = '0;
          periods_d = '0;
        end
      end

      ST_RUN: begin
        // A tick still executes in the cycle stop or pause is seen.
        if (tick_c) begin
          psc_d = '0;
          if (term_c) begin
            cnt_clr_c = 1'b1;
            done_c    = 1'b1;
            if (periods_q != {PER_W{1'b1}}) begin
              periods_d = periods_q + PER_W'(1);
            end
          end else begin
            cnt_en_c = 1'b1;
          end
        end else begin
          psc_d = psc_q + PSC_W'(1);
        end

        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (term_c && !mode_q) begin
          state_d = ST_DONE;
        end else if (bus.pause) begin
          state_d = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (!bus.pause) begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (bus.start) begin
          state_d   = ST_RUN;
          psc_d     = '0;
          periods_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.cfg_ready = cfg_ready_c;
  assign bus.cnt_en    = cnt_en_c;
  assign bus.cnt_clr   = cnt_clr_c;
  assign bus.done      = done_c;
  assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign bus.periods   = periods_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_binary_counter_ctrl.sv
// Bench for binary_counter_ctrl: scenario tasks plus randomized traffic, checked
// against a phase-arithmetic model of the count cycle and a counter datapath model.
module tb_binary_counter_ctrl;

  logic clk;
  logic rst;
  logic [3:0] cnt;

  binary_counter_ctrl_if #(.WIDTH(4), .PSC_W(4), .PER_W(8)) bus ();

  binary_counter_ctrl #(.WIDTH(4), .PSC_W(4), .PER_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter datapath: sync clear has priority, free wrap at 1111.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= 4'h0;
    else if (bus.cnt_clr) cnt <= 4'h0;
    else if (bus.cnt_en)  cnt <= cnt + 4'h1;
  end
  assign bus.cnt_val = cnt;

  int vecs  = 0;
  int fails = 0;

  // Model: state code, limit, prescale, mode, RUN cycles elapsed in the current period, periods.
  int m_st, m_l, m_p, m_mode, m_phase, m_periods;

  task automatic m_reset();
    m_st = 0; m_l = 15; m_p = 0; m_mode = 0; m_phase = 0; m_periods = 0;
  endtask

  function automatic bit m_tick();
    return (m_st == 1) && ((m_phase % (m_p + 1)) == m_p);
  endfunction

  function automatic bit m_term();
    return m_tick() && (m_phase == (m_l + 1) * (m_p + 1) - 1);
  endfunction

  function automatic logic [18:0] exp_vec();
    logic [3:0] c;
    c = (m_st == 0) ? 4'h0 : 4'(m_phase / (m_p + 1));
    return {2'(m_st), 1'(m_st == 1 || m_st == 2), 1'(m_st == 0 || m_st == 3),
            1'(m_tick() && !m_term()), 1'(m_st == 0 || m_term()), 1'(m_term()),
            8'(m_periods), c};
  endfunction

  function automatic logic [18:0] act_vec();
    return {bus.state, bus.busy, bus.cfg_ready, bus.cnt_en, bus.cnt_clr, bus.done,
            bus.periods, (m_st == 0) ? 4'h0 : cnt};
  endfunction

  task automatic model_step();
    bit term, rdy;
    term = m_term();
    rdy  = (m_st == 0) || (m_st == 3);
    case (m_st)
      0: if (!bus.stop && bus.start) begin m_st = 1; m_phase = 0; m_periods = 0; end
      1: begin
        if (term) begin
          m_phase = 0;
          if (m_periods < 255) m_periods++;
        end else begin
          m_phase++;
        end
        if (bus.stop) m_st = 0;
        else if (term && m_mode == 0) m_st = 3;
        else if (bus.pause) m_st = 2;
      end
      2: if (bus.stop) m_st = 0; else if (!bus.pause) m_st = 1;
      default: if (bus.stop) m_st = 0;
               else if (bus.start) begin m_st = 1; m_phase = 0; m_periods = 0; end
    endcase
    if (rdy && bus.cfg_valid) begin
      m_l = int'(bus.cfg_limit); m_p = int'(bus.cfg_prescale); m_mode = int'(bus.cfg_mode);
    end
  endtask

  task automatic clock_step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit cv, int lim, int psc, bit md, bit st, bit sp, bit pa);
    bus.cfg_valid    = cv;
    bus.cfg_limit    = 4'(lim);
    bus.cfg_prescale = 4'(psc);
    bus.cfg_mode     = md;
    bus.start        = st;
    bus.stop         = sp;
    bus.pause        = pa;
  endtask

  task automatic to_idle();
    drive(0, 0, 0, 0, 0, 1, 0);
    clock_step();
    drive(0, 0, 0, 0, 0, 0, 0);
    clock_step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    m_reset();
    @(posedge clk);
    #1;
    vecs++;
    if (act_vec() !== {2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0}) begin
      fails++; $display("FAIL reset_values got %h want %h", act_vec(), exp_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL reset_idle cyc %0d got %h want %h", i, act_vec(), exp_vec());
      end
      clock_step();
    end
  endtask

  task automatic test_one_shot();
    int done_cyc = -1;
    to_idle();
    for (int i = 0; i < 7; i++) begin
      if (i == 0) drive(1, 3, 0, 0, 1, 0, 0); else drive(0, 0, 0, 0, 0, 0, 0);
      if (bus.done && done_cyc < 0) done_cyc = i;
      vecs++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL one_shot cyc %0d got %h want %h", i, act_vec(), exp_vec());
      end
      if (i == 5) begin
        vecs++;
        if (bus.state !== 2'b11 || bus.periods !== 8'd1) begin
          fails++; $display("FAIL one_shot_end state %b periods %0d want 11 / 1", bus.state, bus.periods);
        end
      end
      clock_step();
    end
    vecs++;
    if (done_cyc != 4) begin
      fails++; $display("FAIL one_shot_done_cycle got %0d want 4", done_cyc);
    end
  endtask

  task automatic test_periodic();
    int ndone = 0;
    int last = -1;
    to_idle();
    for (int i = 0; i < 31; i++) begin
      if (i == 0) drive(1, 2, 2, 1, 1, 0, 0); else drive(0, 0, 0, 0, 0, 0, 0);
      if (bus.done && i <= 27) begin
        ndone++;
        if (last >= 0) begin
          vecs++;
          if (i - last != 9) begin
            fails++; $display("FAIL periodic_spacing got %0d want 9", i - last);
          end
        end
        last = i;
      end
      if (i == 28) begin
        vecs++;
        if (bus.periods !== 8'd3) begin
          fails++; $display("FAIL periodic_periods got %0d want 3", bus.periods);
        end
      end
      vecs++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL periodic cyc %0d got %h want %h", i, act_vec(), exp_vec());
      end
      clock_step();
    end
    vecs++;
    if (ndone != 3) begin
      fails++; $display("FAIL periodic_done_count got %0d want 3", ndone);
    end
  endtask

  task automatic test_saturate();
    to_idle();
    for (int i = 0; i < 300; i++) begin
      if (i == 0) drive(1, 0, 0, 1, 1, 0, 0); else drive(0, 0, 0, 0, 0, 0, 0);
      vecs++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL saturate cyc %0d got %h want %h", i, act_vec(), exp_vec());
      end
      if (i == 256 || i == 299) begin
        vecs++;
        if (bus.periods !== 8'd255 || bus.done !== 1'b1) begin
          fails++; $display("FAIL saturate_cap cyc %0d periods %0d done %b want 255 / 1", i, bus.periods, bus.done);
        end
      end
      clock_step();
    end
  endtask

  task automatic test_pause();
    int done_cyc = -1;
    to_idle();
    for (int i = 0; i < 32; i++) begin
      if (i == 0) drive(1, 5, 3, 1, 1, 0, 0);
      else drive(0, 0, 0, 0, 0, 0, (i >= 6 && i <= 10));
      if (bus.done && done_cyc < 0) done_cyc = i;
      vecs++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL pause cyc %0d got %h want %h", i, act_vec(), exp_vec());
      end
      clock_step();
    end
    vecs++;
    if (done_cyc != 29) begin
      fails++; $display("FAIL pause_extension first done cyc %0d want 29", done_cyc);
    end
  endtask

  task automatic test_stop_terminal();
    int early = 0;
    int late_cyc = -1;
    to_idle();
    for (int i = 0; i < 13; i++) begin
      if (i == 0)      drive(1, 1, 0, 1, 1, 0, 0);
      else if (i == 2) drive(0, 0, 0, 0, 0, 1, 0);
      else if (i == 3) drive(1, 5, 0, 0, 1, 0, 0);
      else             drive(0, 0, 0, 0, 0, 0, 0);
      if (bus.done && i <= 3) early++;
      if (bus.done && i > 3 && late_cyc < 0) late_cyc = i;
      if (i == 3) begin
        vecs++;
        if (bus.state !== 2'b00 || bus.cnt_clr !== 1'b1) begin
          fails++; $display("FAIL stop_to_idle state %b clr %b want 00 / 1", bus.state, bus.cnt_clr);
        end
      end
      vecs++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL stop_terminal cyc %0d got %h want %h", i, act_vec(), exp_vec());
      end
      clock_step();
    end
    vecs++;
    if (early != 1 || late_cyc - 3 != 6) begin
      fails++; $display("FAIL stop_restart done pulses %0d gap %0d want 1 / 6", early, late_cyc - 3);
    end
  endtask

  task automatic test_reset_mid();
    to_idle();
    for (int i = 0; i < 9; i++) begin
      if (i == 0)                drive(1, 10, 0, 0, 1, 0, 0);
      else if (i >= 3 && i <= 5) drive(1, 2, 1, 1, 0, 0, 0);
      else                       drive(0, 0, 0, 0, 0, 0, 0);
      if (i == 4) begin
        vecs++;
        if (bus.cfg_ready !== 1'b0) begin
          fails++; $display("FAIL cfg_held_off cfg_ready %b want 0", bus.cfg_ready);
        end
      end
      vecs++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL reset_mid cyc %0d got %h want %h", i, act_vec(), exp_vec());
      end
      if (i < 8) clock_step();
    end
    vecs++;
    if (cnt !== 4'd7) begin
      fails++; $display("FAIL reset_mid_pre cnt_val %0d want 7", cnt);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    vecs++;
    if ({bus.state, bus.busy, bus.cfg_ready, bus.cnt_en, bus.cnt_clr, bus.done, bus.periods}
        !== {2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00}) begin
      fails++; $display("FAIL async_reset state %b busy %b rdy %b en %b clr %b done %b per %0d",
                        bus.state, bus.busy, bus.cfg_ready, bus.cnt_en, bus.cnt_clr, bus.done, bus.periods);
    end
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL reset_mid_after cyc %0d got %h want %h", i, act_vec(), exp_vec());
      end
      clock_step();
    end
  endtask

  task automatic test_random();
    to_idle();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 10) < 3, int'($urandom % 16), int'($urandom % 4), bit'($urandom % 2),
            ($urandom % 5) == 0, ($urandom % 40) == 0, ($urandom % 10) == 0);
      vecs++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL random cyc %0d got %h want %h", i, act_vec(), exp_vec());
      end
      clock_step();
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_saturate();
    test_pause();
    test_stop_terminal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
